// File: rtl/pl_reset_sequencer.sv
// rtl/pl_reset_sequencer.sv - PL reset sequencer: MMCM lock debounce, ordered reset release, lock-loss and warm-reset handling
module pl_reset_sequencer #(
    parameter int LOCK_DEBOUNCE = 16,
    parameter int IC_HOLD       = 8,
    parameter int PERIPH_HOLD   = 8,
    parameter int SW_RST_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             pl_clk0,
    input  logic             pl0_resetn,
    input  logic             locked,
    input  logic             sw_rst_req,
    output logic             ic_resetn,
    output logic             periph_resetn,
    output logic             periph_reset,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_DEBOUNCE   = 3'd2,
        ST_REL_IC     = 3'd3,
        ST_REL_PERIPH = 3'd4,
        ST_RUN        = 3'd5,
        ST_SWRST      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(LOCK_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] IC_LAST  = CNT_W'(IC_HOLD - 1);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PERIPH_HOLD - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_lock_loss_cnt;
    logic             w_lock_loss;
    logic             r_ic_resetn;
    logic             r_periph_resetn;
    logic             r_periph_reset;
    logic             r_ready;

    // locked comes from the clk_wizard domain; only r_sync2 may be used by the FSM
    always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
        if (!pl0_resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_lock_loss = 1'b0;
        case (r_state)
            ST_RESET: w_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (r_sync2) begin
                    w_next     = ST_DEBOUNCE;
                    w_cnt_next = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!r_sync2) begin
                    w_next = ST_WAIT_LOCK;
                end else if (r_cnt == DEB_LAST) begin
                    w_next     = ST_REL_IC;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_REL_IC, ST_REL_PERIPH, ST_RUN: begin
                // lock loss outranks both hold expiry and a software request
                if (!r_sync2) begin
                    w_next      = ST_WAIT_LOCK;
                    w_cnt_next  = '0;
                    w_lock_loss = 1'b1;
                end else if (r_state == ST_RUN) begin
                    if (sw_rst_req) begin
                        w_next     = ST_SWRST;
                        w_cnt_next = '0;
                    end
                end else if (r_state == ST_REL_IC) begin
                    if (r_cnt == IC_LAST) begin
                        w_next     = ST_REL_PERIPH;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else begin
                    if (r_cnt == PH_LAST) begin
                        w_next     = ST_RUN;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
            end
            ST_SWRST: begin
                if (r_cnt == SW_LAST) begin
                    w_next     = ST_WAIT_LOCK;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next     = ST_RESET;
                w_cnt_next = '0;
            end
        endcase
    end

    // outputs decode the next state so they switch on the same edge as the state
    always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
        if (!pl0_resetn) begin
            r_state         <= ST_RESET;
            r_cnt           <= '0;
            r_lock_loss_cnt <= '0;
            r_ic_resetn     <= 1'b0;
            r_periph_resetn <= 1'b0;
            r_periph_reset  <= 1'b1;
            r_ready         <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_cnt           <= w_cnt_next;
            if (w_lock_loss && (r_lock_loss_cnt != CNT_MAX)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + CNT_ONE;
            end
            r_ic_resetn     <= (w_next == ST_REL_IC) || (w_next == ST_REL_PERIPH) || (w_next == ST_RUN);
            r_periph_resetn <= (w_next == ST_REL_PERIPH) || (w_next == ST_RUN);
            r_periph_reset  <= !((w_next == ST_REL_PERIPH) || (w_next == ST_RUN));
            r_ready         <= (w_next == ST_RUN);
        end
    end

    assign ic_resetn     = r_ic_resetn;
    assign periph_resetn = r_periph_resetn;
    assign periph_reset  = r_periph_reset;
    assign ready         = r_ready;
    assign state         = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// tb/tb_pl_reset_sequencer.sv - self-checking bench for pl_reset_sequencer: directed vector table, corner sequences, random run vs timeline model
module tb_pl_reset_sequencer;

    localparam int LD   = 16;
    localparam int IC   = 8;
    localparam int PH   = 8;
    localparam int SW   = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          pl_clk0    = 1'b0;
    logic          pl0_resetn = 1'b0;
    logic          locked     = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic          ic_resetn;
    logic          periph_resetn;
    logic          periph_reset;
    logic          ready;
    logic [2:0]    state;
    logic [CW-1:0] lock_loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pl_reset_sequencer #(
        .LOCK_DEBOUNCE(LD),
        .IC_HOLD(IC),
        .PERIPH_HOLD(PH),
        .SW_RST_CYCLES(SW),
        .CNT_W(CW)
    ) dut (
        .pl_clk0(pl_clk0),
        .pl0_resetn(pl0_resetn),
        .locked(locked),
        .sw_rst_req(sw_rst_req),
        .ic_resetn(ic_resetn),
        .periph_resetn(periph_resetn),
        .periph_reset(periph_reset),
        .ready(ready),
        .state(state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 pl_clk0 = ~pl_clk0;

    typedef struct {
        logic lk;
        logic sw;
        int   n;
        int   st;
        int   ic;
        int   pr;
        int   rdy;
        int   cnt;
    } vec_t;

    vec_t vt[$];

    // Timeline model: a lock sequence is a start edge plus elapsed time;
    // the expected state is read off the release schedule arithmetically.
    int   m_mode;   // 0 reset, 1 waiting for lock, 2 release timeline, 3 software reset
    int   m_t0;
    int   m_k;
    int   m_cnt;
    int   m_state;
    logic lq[$];

    function automatic int phase(input int e);
        if (e < LD) return 2;
        if (e < LD + IC) return 3;
        if (e < LD + IC + PH) return 4;
        return 5;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_t0    = 0;
        m_cnt   = 0;
        m_state = 0;
        lq.delete();
        lq.push_back(1'b0);
        lq.push_back(1'b0);
    endtask

    task automatic model_edge(input logic lk, input logic sw);
        logic ls;
        int   cur;
        ls = lq.pop_front();
        lq.push_back(lk);
        m_k++;
        case (m_mode)
            0: m_mode = 1;
            1: if (ls) begin m_mode = 2; m_t0 = m_k; end
            2: begin
                cur = phase(m_k - 1 - m_t0);
                if (!ls) begin
                    if (cur != 2 && m_cnt < CMAX) m_cnt++;
                    m_mode = 1;
                end else if (cur == 5 && sw) begin
                    m_mode = 3;
                    m_t0   = m_k;
                end
            end
            default: if (m_k - m_t0 >= SW) m_mode = 1;
        endcase
        case (m_mode)
            0:       m_state = 0;
            1:       m_state = 1;
            2:       m_state = phase(m_k - m_t0);
            default: m_state = 6;
        endcase
    endtask

    task automatic tick();
        @(posedge pl_clk0);
        if (!pl0_resetn) model_reset();
        else model_edge(locked, sw_rst_req);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int st, input int ic, input int pr, input int rdy, input int cnt);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".ic_resetn"}, int'(ic_resetn), ic);
        chk({name, ".periph_resetn"}, int'(periph_resetn), pr);
        chk({name, ".periph_reset"}, int'(periph_reset), (pr == 0) ? 1 : 0);
        chk({name, ".ready"}, int'(ready), rdy);
        chk({name, ".lock_loss_cnt"}, int'(lock_loss_cnt), cnt);
    endtask

    task automatic chk_model(input string name);
        chk_out(name, m_state, (m_state >= 3 && m_state <= 5) ? 1 : 0,
                (m_state == 4 || m_state == 5) ? 1 : 0, (m_state == 5) ? 1 : 0, m_cnt);
        chk({name, ".glitch"}, int'(periph_resetn & ~ic_resetn), 0);
    endtask

    function automatic void add(input logic lk, input logic sw, input int n, input int st,
                                input int ic, input int pr, input int rdy, input int cnt);
        vec_t v;
        v.lk = lk; v.sw = sw; v.n = n; v.st = st;
        v.ic = ic; v.pr = pr; v.rdy = rdy; v.cnt = cnt;
        vt.push_back(v);
    endfunction

    initial begin
        bit timed_out;

        // {locked, sw (first edge only), edges, state, ic, periph, ready, lock_loss_cnt}; comments give absolute edge
        add(1, 0,  1, 1, 0, 0, 0, 0);  // 1
        add(1, 0,  1, 1, 0, 0, 0, 0);  // 2
        add(1, 0,  1, 2, 0, 0, 0, 0);  // 3
        add(1, 0, 15, 2, 0, 0, 0, 0);  // 18
        add(1, 0,  1, 3, 1, 0, 0, 0);  // 19
        add(1, 0,  7, 3, 1, 0, 0, 0);  // 26
        add(1, 0,  1, 4, 1, 1, 0, 0);  // 27
        add(1, 0,  7, 4, 1, 1, 0, 0);  // 34
        add(1, 0,  1, 5, 1, 1, 1, 0);  // 35
        add(1, 0,  5, 5, 1, 1, 1, 0);  // 40
        add(1, 1,  1, 6, 0, 0, 0, 0);  // 41 software reset
        add(1, 1,  1, 6, 0, 0, 0, 0);  // 42 second request ignored
        add(1, 0, 14, 6, 0, 0, 0, 0);  // 56
        add(1, 0,  1, 1, 0, 0, 0, 0);  // 57
        add(1, 0,  1, 2, 0, 0, 0, 0);  // 58
        add(1, 0, 31, 4, 1, 1, 0, 0);  // 89
        add(1, 0,  1, 5, 1, 1, 1, 0);  // 90
        add(0, 0,  2, 5, 1, 1, 1, 0);  // 92 lock loss in flight through synchroniser
        add(0, 0,  1, 1, 0, 0, 0, 1);  // 93
        add(1, 0,  2, 1, 0, 0, 0, 1);  // 95
        add(1, 0,  1, 2, 0, 0, 0, 1);  // 96
        add(1, 0, 16, 3, 1, 0, 0, 1);  // 112
        add(1, 0, 16, 5, 1, 1, 1, 1);  // 128
        add(0, 0,  2, 5, 1, 1, 1, 1);  // 130
        add(0, 1,  1, 1, 0, 0, 0, 2);  // 131 sw request collides with lock loss
        add(1, 0,  2, 1, 0, 0, 0, 2);  // 133
        add(1, 0,  1, 2, 0, 0, 0, 2);  // 134
        add(1, 0,  9, 2, 0, 0, 0, 2);  // 143
        add(0, 0,  1, 2, 0, 0, 0, 2);  // 144 one-cycle lock drop
        add(1, 0,  1, 2, 0, 0, 0, 2);  // 145
        add(1, 0,  1, 1, 0, 0, 0, 2);  // 146 debounce abort, not counted
        add(1, 0,  1, 2, 0, 0, 0, 2);  // 147
        add(1, 0, 15, 2, 0, 0, 0, 2);  // 162
        add(1, 0,  1, 3, 1, 0, 0, 2);  // 163
        add(1, 0,  8, 4, 1, 1, 0, 2);  // 171
        add(1, 0,  2, 4, 1, 1, 0, 2);  // 173

        model_reset();
        locked = 1'b1;
        repeat (3) tick();
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge pl_clk0);
        pl0_resetn = 1'b1;

        foreach (vt[i]) begin
            locked = vt[i].lk;
            for (int j = 0; j < vt[i].n; j++) begin
                sw_rst_req = (j == 0) ? vt[i].sw : 1'b0;
                tick();
            end
            sw_rst_req = 1'b0;
            chk_out($sformatf("vec%0d", i), vt[i].st, vt[i].ic, vt[i].pr, vt[i].rdy, vt[i].cnt);
        end

        // asynchronous reset between edges while in REL_PERIPH
        #2;
        pl0_resetn = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0);
        @(negedge pl_clk0);
        pl0_resetn = 1'b1;

        // saturation: 300 lock losses, each after reaching REL_IC
        timed_out = 1'b0;
        for (int i = 0; i < 300 && !timed_out; i++) begin
            locked = 1'b1;
            for (int w = 0; w < 60 && state != 3'd3; w++) tick();
            if (state != 3'd3) timed_out = 1'b1;
            locked = 1'b0;
            for (int w = 0; w < 8 && state != 3'd1; w++) tick();
            if (state != 3'd1) timed_out = 1'b1;
            if (i == 199) chk("sat.cnt200", int'(lock_loss_cnt), 200);
        end
        if (timed_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sat.timeout: state %0d did not reach the expected value in its cycle budget", state);
        end
        chk("sat.cnt255", int'(lock_loss_cnt), CMAX);

        // randomized run against the timeline model
        @(negedge pl_clk0);
        pl0_resetn = 1'b0;
        tick();
        chk_model("rand_rst");
        @(negedge pl_clk0);
        pl0_resetn = 1'b1;
        locked     = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            chk_model("rand");
            if (locked) begin
                if ($urandom_range(0, 59) == 0) locked = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                locked = 1'b1;
            end
            sw_rst_req = ($urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
